// File: rtl/axil_slave_wr_if.sv
// AXI-Lite write-channel bundle (AW, W, B) between an interconnect-side
// master and a register-bank slave.
//   awaddr/awvalid/awready : write address channel
//   wdata/wstrb/wvalid/wready : write data channel, one strobe bit per byte
//   bresp/bvalid/bready : write response channel
// Modports: master drives AW/W valids and bready; slave drives readies and B.
interface axil_slave_wr_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axil_slave_wr.sv
// AXI-Lite write responder terminating AW/W/B into a local register bank.
// AW and W are accepted independently in either order; the write commits on
// the edge entering RESP, byte-wise under wstrb, and B returns OKAY for a
// mapped address or DECERR for an unmapped one. One write outstanding.
// Ports:
//   aclk, aresetn : clock (rising edge), asynchronous active-low reset
//   s_axil        : AXI-Lite write channels (slave modport)
//   regs_out      : flat register contents, register i at [i*W +: W]
//   wr_pulse      : one-cycle pulse, bit i set when register i was written
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no write in flight; both channels ready (after reset)
// ST_WAIT_W  | address captured, waiting for write data
// ST_WAIT_AW | data/strobes captured, waiting for write address
// ST_RESP    | write committed, bvalid held until bready
module axil_slave_wr #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int NUM_REGS       = 16,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   axil_slave_wr_if.slave                     s_axil,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]                wr_pulse
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_W,
      ST_WAIT_AW,
      ST_RESP
   } state_t;

   state_t                    state;
   logic                      awready_q;
   logic                      wready_q;
   logic                      bvalid_q;
   logic [1:0]                bresp_q;
   logic [NUM_REGS-1:0]       wr_pulse_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_DATA_WIDTH-1:0] data_q;
   logic [STRB_W-1:0]         strb_q;
   logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];

   logic                      aw_hs;
   logic                      w_hs;
   logic                      commit;
   logic [AXI_ADDR_WIDTH-1:0] c_addr;
   logic [AXI_DATA_WIDTH-1:0] c_data;
   logic [STRB_W-1:0]         c_strb;
   logic [AXI_ADDR_WIDTH-1:0] c_off;
   logic [AXI_ADDR_WIDTH-1:0] c_idx;
   logic                      mapped;
   logic [NUM_REGS-1:0]       hit;

   assign aw_hs = s_axil.awvalid & awready_q;
   assign w_hs  = s_axil.wvalid  & wready_q;

   // Readies are only ever high in states where that handshake is legal,
   // so the state qualifier only selects which completion applies.
   assign commit = ((state == ST_IDLE)    & aw_hs & w_hs) |
                   ((state == ST_WAIT_W)  & w_hs) |
                   ((state == ST_WAIT_AW) & aw_hs);

   // Whichever half arrived earlier comes from the holding register.
   assign c_addr = (state == ST_WAIT_W)  ? addr_q : s_axil.awaddr;
   assign c_data = (state == ST_WAIT_AW) ? data_q : s_axil.wdata;
   assign c_strb = (state == ST_WAIT_AW) ? strb_q : s_axil.wstrb;

   // The below-base test guards against the subtraction wrapping into range.
   assign c_off  = c_addr - BASE_ADDR;
   assign c_idx  = c_off >> ADDR_LSB;
   assign mapped = (c_addr >= BASE_ADDR) &&
                   (c_idx < AXI_ADDR_WIDTH'(NUM_REGS));

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         hit[i] = mapped && (c_idx == AXI_ADDR_WIDTH'(i));
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
      end else begin
         wr_pulse_q <= '0;
         if (commit) begin
            wr_pulse_q <= hit;
            bvalid_q   <= 1'b1;
            bresp_q    <= mapped ? RESP_OKAY : RESP_DECERR;
         end
         case (state)
            ST_IDLE: begin
               if (aw_hs && w_hs) begin
                  state     <= ST_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
               end else if (aw_hs) begin
                  state     <= ST_WAIT_W;
                  addr_q    <= s_axil.awaddr;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
               end else if (w_hs) begin
                  state     <= ST_WAIT_AW;
                  data_q    <= s_axil.wdata;
                  strb_q    <= s_axil.wstrb;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
               end else begin
                  // Also raises the readies on the first edge out of reset.
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            ST_WAIT_W: begin
               if (w_hs) begin
                  state    <= ST_RESP;
                  wready_q <= 1'b0;
               end
            end
            ST_WAIT_AW: begin
               if (aw_hs) begin
                  state     <= ST_RESP;
                  awready_q <= 1'b0;
               end
            end
            ST_RESP: begin
               if (s_axil.bready) begin
                  state     <= ST_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (hit[i]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (c_strb[b]) begin
                     regs_q[i][b*8 +: 8] <= c_data[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
   end

   assign s_axil.awready = awready_q;
   assign s_axil.wready  = wready_q;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign wr_pulse       = wr_pulse_q;

endmodule

// File: tb/tb_axil_slave_wr.sv
// Directed bench for axil_slave_wr at default parameters (32-bit data,
// 16 registers, base 0). Inputs change and outputs are sampled 1 ns after
// the rising edge.
module tb_axil_slave_wr;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 16;

   logic          aclk;
   logic          aresetn;
   logic [NR*DW-1:0] regs_out;
   logic [NR-1:0]    wr_pulse;

   int errors;
   int checks;

   axil_slave_wr_if #(.ADDR_W(AW), .DATA_W(DW)) s_axil ();

   axil_slave_wr #(
      .AXI_DATA_WIDTH(DW),
      .AXI_ADDR_WIDTH(AW),
      .NUM_REGS      (NR),
      .BASE_ADDR     ('0)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_axil  (s_axil),
      .regs_out(regs_out),
      .wr_pulse(wr_pulse)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Full write with AW and W presented together; ok reports whether B came.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
      ok = 1'b0;
      s_axil.awaddr  = a;
      s_axil.awvalid = 1'b1;
      s_axil.wdata   = d;
      s_axil.wstrb   = s;
      s_axil.wvalid  = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (s_axil.bvalid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (s_axil.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", s_axil.awready); end
      checks++; if (s_axil.wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", s_axil.wready); end
      checks++; if (s_axil.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", s_axil.bvalid); end
      checks++; if (s_axil.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", s_axil.bresp); end
      checks++; if (wr_pulse !== 16'h0000) begin errors++; $display("FAIL rst_pulse got %h want 0000", wr_pulse); end
      checks++; if (regs_out !== '0) begin errors++; $display("FAIL rst_regs got nonzero want 0"); end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      #1;
      checks++; if (s_axil.awready !== 1'b0) begin errors++; $display("FAIL rel_awready_pre got %b want 0", s_axil.awready); end
      step();
      checks++; if (s_axil.awready !== 1'b1) begin errors++; $display("FAIL rel_awready got %b want 1", s_axil.awready); end
      checks++; if (s_axil.wready !== 1'b1) begin errors++; $display("FAIL rel_wready got %b want 1", s_axil.wready); end
   endtask

   task automatic test_simultaneous();
      s_axil.awaddr  = 32'h8;
      s_axil.awvalid = 1'b1;
      s_axil.wdata   = 32'hDEADBEEF;
      s_axil.wstrb   = 4'hF;
      s_axil.wvalid  = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL sim_bvalid got %b want 1", s_axil.bvalid); end
      checks++; if (s_axil.bresp !== 2'b00) begin errors++; $display("FAIL sim_bresp got %b want 00", s_axil.bresp); end
      checks++; if (regs_out[2*DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_reg2 got %h want deadbeef", regs_out[2*DW +: DW]); end
      checks++; if (wr_pulse !== 16'h0004) begin errors++; $display("FAIL sim_pulse got %h want 0004", wr_pulse); end
      checks++; if (s_axil.awready !== 1'b0 || s_axil.wready !== 1'b0) begin errors++; $display("FAIL sim_ready got %b%b want 00", s_axil.awready, s_axil.wready); end
      step();
      checks++; if (wr_pulse !== 16'h0000) begin errors++; $display("FAIL sim_pulse_clr got %h want 0000", wr_pulse); end
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL sim_bvalid_hold got %b want 1", s_axil.bvalid); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b0) begin errors++; $display("FAIL sim_bvalid_clr got %b want 0", s_axil.bvalid); end
      checks++; if (s_axil.awready !== 1'b1 || s_axil.wready !== 1'b1) begin errors++; $display("FAIL sim_ready_back got %b%b want 11", s_axil.awready, s_axil.wready); end
   endtask

   task automatic test_w_first();
      s_axil.wdata  = 32'h11223344;
      s_axil.wstrb  = 4'hF;
      s_axil.wvalid = 1'b1;
      step();
      s_axil.wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (s_axil.awready !== 1'b1 || s_axil.wready !== 1'b0) begin errors++; $display("FAIL wf_ready[%0d] got %b%b want 10", i, s_axil.awready, s_axil.wready); end
         checks++; if (s_axil.bvalid !== 1'b0) begin errors++; $display("FAIL wf_bvalid[%0d] got %b want 0", i, s_axil.bvalid); end
         if (i < 2) step();
      end
      s_axil.awaddr  = 32'h4;
      s_axil.awvalid = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL wf_bvalid got %b want 1", s_axil.bvalid); end
      checks++; if (regs_out[1*DW +: DW] !== 32'h11223344) begin errors++; $display("FAIL wf_reg1 got %h want 11223344", regs_out[1*DW +: DW]); end
      checks++; if (wr_pulse !== 16'h0002) begin errors++; $display("FAIL wf_pulse got %h want 0002", wr_pulse); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   task automatic test_strobe();
      bit ok;
      do_write(32'h0, 32'hFFFFFFFF, 4'hF, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL strb_b1 got timeout want bvalid"); end
      checks++; if (regs_out[0 +: DW] !== 32'hFFFFFFFF) begin errors++; $display("FAIL strb_reg0a got %h want ffffffff", regs_out[0 +: DW]); end
      do_write(32'h0, 32'h00000000, 4'h5, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL strb_b2 got timeout want bvalid"); end
      checks++; if (regs_out[0 +: DW] !== 32'hFF00FF00) begin errors++; $display("FAIL strb_reg0b got %h want ff00ff00", regs_out[0 +: DW]); end
   endtask

   task automatic test_decerr();
      logic [NR*DW-1:0] exp_flat;
      exp_flat = '0;
      exp_flat[0*DW +: DW] = 32'hFF00FF00;
      exp_flat[1*DW +: DW] = 32'h11223344;
      exp_flat[2*DW +: DW] = 32'hDEADBEEF;
      s_axil.awaddr  = 32'h40;
      s_axil.awvalid = 1'b1;
      s_axil.wdata   = 32'hCAFEF00D;
      s_axil.wstrb   = 4'hF;
      s_axil.wvalid  = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL dec_bvalid got %b want 1", s_axil.bvalid); end
      checks++; if (s_axil.bresp !== 2'b11) begin errors++; $display("FAIL dec_bresp got %b want 11", s_axil.bresp); end
      checks++; if (wr_pulse !== 16'h0000) begin errors++; $display("FAIL dec_pulse got %h want 0000", wr_pulse); end
      checks++; if (regs_out !== exp_flat) begin errors++; $display("FAIL dec_regs got changed want unchanged"); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   task automatic test_zero_strb();
      s_axil.awaddr  = 32'h8;
      s_axil.awvalid = 1'b1;
      s_axil.wdata   = 32'h12345678;
      s_axil.wstrb   = 4'h0;
      s_axil.wvalid  = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      checks++; if (s_axil.bresp !== 2'b00) begin errors++; $display("FAIL zs_bresp got %b want 00", s_axil.bresp); end
      checks++; if (wr_pulse !== 16'h0004) begin errors++; $display("FAIL zs_pulse got %h want 0004", wr_pulse); end
      checks++; if (regs_out[2*DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL zs_reg2 got %h want deadbeef", regs_out[2*DW +: DW]); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   task automatic test_bready_stall();
      s_axil.awaddr  = 32'hC;
      s_axil.awvalid = 1'b1;
      s_axil.wdata   = 32'hA5A5A5A5;
      s_axil.wstrb   = 4'hF;
      s_axil.wvalid  = 1'b1;
      step();
      // Next write is offered immediately; low address bits must be ignored.
      s_axil.awaddr = 32'h13;
      s_axil.wdata  = 32'h5A5A5A5A;
      for (int i = 0; i < 5; i++) begin
         checks++; if (s_axil.bvalid !== 1'b1 || s_axil.bresp !== 2'b00) begin errors++; $display("FAIL st_b[%0d] got %b/%b want 1/00", i, s_axil.bvalid, s_axil.bresp); end
         checks++; if (s_axil.awready !== 1'b0 || s_axil.wready !== 1'b0) begin errors++; $display("FAIL st_ready[%0d] got %b%b want 00", i, s_axil.awready, s_axil.wready); end
         step();
      end
      checks++; if (regs_out[3*DW +: DW] !== 32'hA5A5A5A5) begin errors++; $display("FAIL st_reg3 got %h want a5a5a5a5", regs_out[3*DW +: DW]); end
      checks++; if (regs_out[4*DW +: DW] !== 32'h0) begin errors++; $display("FAIL st_reg4_early got %h want 0", regs_out[4*DW +: DW]); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b0 || s_axil.awready !== 1'b1) begin errors++; $display("FAIL st_release got %b/%b want 0/1", s_axil.bvalid, s_axil.awready); end
      step();
      s_axil.awvalid = 1'b0;
      s_axil.wvalid  = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL st_second_b got %b want 1", s_axil.bvalid); end
      checks++; if (regs_out[4*DW +: DW] !== 32'h5A5A5A5A) begin errors++; $display("FAIL st_reg4 got %h want 5a5a5a5a", regs_out[4*DW +: DW]); end
      checks++; if (wr_pulse !== 16'h0010) begin errors++; $display("FAIL st_pulse got %h want 0010", wr_pulse); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   task automatic test_reset_mid();
      s_axil.awaddr  = 32'h14;
      s_axil.awvalid = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      checks++; if (s_axil.awready !== 1'b0 || s_axil.wready !== 1'b1) begin errors++; $display("FAIL rm_waitw got %b%b want 01", s_axil.awready, s_axil.wready); end
      aresetn = 1'b0;
      #1;
      checks++; if (s_axil.awready !== 1'b0 || s_axil.wready !== 1'b0) begin errors++; $display("FAIL rm_ready got %b%b want 00", s_axil.awready, s_axil.wready); end
      checks++; if (s_axil.bvalid !== 1'b0 || s_axil.bresp !== 2'b00) begin errors++; $display("FAIL rm_b got %b/%b want 0/00", s_axil.bvalid, s_axil.bresp); end
      checks++; if (regs_out !== '0) begin errors++; $display("FAIL rm_regs got nonzero want 0"); end
      step();
      aresetn = 1'b1;
      step();
      checks++; if (s_axil.awready !== 1'b1 || s_axil.wready !== 1'b1) begin errors++; $display("FAIL rm_ready_up got %b%b want 11", s_axil.awready, s_axil.wready); end
      s_axil.wdata  = 32'h0BADF00D;
      s_axil.wstrb  = 4'hF;
      s_axil.wvalid = 1'b1;
      step();
      s_axil.wvalid = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b0) begin errors++; $display("FAIL rm_no_b got %b want 0", s_axil.bvalid); end
      checks++; if (wr_pulse !== 16'h0000) begin errors++; $display("FAIL rm_no_pulse got %h want 0000", wr_pulse); end
      s_axil.awaddr  = 32'h14;
      s_axil.awvalid = 1'b1;
      step();
      s_axil.awvalid = 1'b0;
      checks++; if (s_axil.bvalid !== 1'b1) begin errors++; $display("FAIL rm_b_after got %b want 1", s_axil.bvalid); end
      checks++; if (regs_out[5*DW +: DW] !== 32'h0BADF00D) begin errors++; $display("FAIL rm_reg5 got %h want 0badf00d", regs_out[5*DW +: DW]); end
      checks++; if (wr_pulse !== 16'h0020) begin errors++; $display("FAIL rm_pulse got %h want 0020", wr_pulse); end
      s_axil.bready = 1'b1;
      step();
      s_axil.bready = 1'b0;
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      aresetn        = 1'b0;
      s_axil.awaddr  = '0;
      s_axil.awvalid = 1'b0;
      s_axil.wdata   = '0;
      s_axil.wstrb   = '0;
      s_axil.wvalid  = 1'b0;
      s_axil.bready  = 1'b0;
      test_reset();
      test_simultaneous();
      test_w_first();
      test_strobe();
      test_decerr();
      test_zero_strb();
      test_bready_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
